// File: rtl/normalizer_pkg.sv
// Shared types and defaults for the iterative left-normalizer.
// Imported by seq_normalizer.
package normalizer_pkg;

  localparam int NORM_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } norm_state_t;

endpackage

// File: rtl/BarrelShifter.sv
// Combinational barrel shifter, zero fill in both directions.
// shift_direction: 1 = left, 0 = right.
module BarrelShifter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH)-1:0] shift_amount,
  input  logic                     shift_direction,
  output logic [WIDTH-1:0]         data_out
);

  assign data_out = shift_direction ? (data_in << shift_amount)
                                    : (data_in >> shift_amount);

endmodule

// File: rtl/seq_normalizer.sv
// Iterative left-normalizer: shifts one bit per cycle until the
// leading one reaches the MSB, reporting how far it moved.
module seq_normalizer
  import normalizer_pkg::*;
#(
  parameter int WIDTH = NORM_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(WIDTH)-1:0] shift_amount,
  output logic                     zero_flag
);

  localparam int CW = $clog2(WIDTH);

  norm_state_t      state;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    count;
  logic             zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      count <= '0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= data_in;
            count <= '0;
            if (data_in == '0) begin
              zero  <= 1'b1;
              state <= DONE;
            end else begin
              zero  <= 1'b0;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // Nonzero input guarantees a one reaches the MSB
          // within WIDTH-1 shifts, so count never wraps.
          if (work[WIDTH-1]) begin
            state <= DONE;
          end else begin
            work  <= work << 1;
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state == IDLE) && !rst;
  assign out_valid    = (state == DONE);
  assign data_out     = work;
  assign shift_amount = count;
  assign zero_flag    = zero;

endmodule

// File: doc/seq_normalizer.md
Name: seq_normalizer

Overview:
- Iterative left-normalizer: the inverse of the barrel shifter. The shifter turns (data, amount) into shifted data; this block turns data into the left-shift amount that brings its leading one to the MSB.
- Also returns the normalized word, so that data_out == data_in << shift_amount.
- Sits ahead of the barrel shifter in fixed-point/float-style datapaths (normalize, then denormalize by the same amount).
- Shifts one bit per cycle.
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, data word width in bits; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block can accept an input.
- data_in  input  WIDTH  word to normalize.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- data_out  output  WIDTH  normalized word.
- shift_amount  output  $clog2(WIDTH)  number of leading zeros removed.
- zero_flag  output  1  input was all zeros.

Behaviour:
- Reset:
  - rst is synchronous, active-high, sampled on rising clk.
  - Next state is IDLE; out_valid=0, data_out=0, shift_amount=0, zero_flag=0.
  - in_ready=0 in any cycle where rst=1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1; out_valid=0.
  - On in_valid&&in_ready: capture data_in into the work register and clear the count.
  - If data_in==0: go to DONE with zero_flag=1, shift_amount=0, data_out=0.
  - Otherwise: go to SHIFT with zero_flag=0.
- SHIFT:
  - in_ready=0.
  - If work[WIDTH-1]==1: go to DONE.
  - Otherwise: work <= work<<1 (zero fill) and count <= count+1.
  - The count cannot exceed WIDTH-1 for a nonzero input, so no wrap is possible.
- DONE:
  - out_valid=1; data_out, shift_amount and zero_flag are driven from registers.
  - Outputs stay stable until out_ready=1.
  - On out_valid&&out_ready: return to IDLE.
  - There is no same-cycle accept of new input in DONE; in_ready=0.
- Latency:
  - For an input with k leading zeros, out_valid rises k+1 cycles after the accept edge (k=0 gives 1 cycle, k=WIDTH-1 gives WIDTH cycles).
  - A zero input gives out_valid 1 cycle after accept.
- Throughput: each item takes k+1 cycles, plus at least 1 DONE cycle, plus 1 IDLE cycle.
- Backpressure: out_ready may be held low indefinitely. The result must hold and in_valid is ignored.
- Reset mid-operation: rst in SHIFT or DONE abandons the item. out_valid is 0 from the next cycle and the item is never presented.
- Simultaneous rst with in_valid or out_ready: rst wins, and no transfer occurs.
- Invariants when out_valid=1 and zero_flag=0:
  - data_out[WIDTH-1]==1.
  - data_out == data_in << shift_amount.
  - (data_out >> shift_amount) == data_in.
- out_valid and in_ready are never 1 in the same cycle.
- in_valid is not required to stay asserted after acceptance, and data_in is not sampled after acceptance.

Decomposition:
- Package normalizer_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} norm_state_t;
  - the default WIDTH constant.
- The RTL needs no sub-module: a single module with one FSM, one work register and one counter.
- The bench instantiates BarrelShifter as a reference model. It right-shifts data_out by shift_amount (shift_direction=0) and compares the result against data_in.

Test Plan (WIDTH=8):
- Accept 8'b00000101 → 6 cycles later out_valid=1, data_out=8'b10100000, shift_amount=5, zero_flag=0.
- Accept 8'b10101010 → 1 cycle later out_valid=1, data_out=8'b10101010, shift_amount=0.
- Accept 8'b00000001 → 8 cycles later data_out=8'b10000000, shift_amount=7. Accept 8'h00 → 1 cycle later zero_flag=1, shift_amount=0, data_out=0.
- Backpressure: out_ready=0 for 5 cycles after the 8'b00010000 result while in_valid=1 with 8'hFF. Required: outputs hold (8'b10000000, shift_amount=3), in_ready=0, 8'hFF is not accepted. Then out_ready=1 → IDLE; 8'hFF is accepted the next cycle and yields shift_amount=0.
- Reset mid-operation: accept 8'b00000001, assert rst for 1 cycle on the 3rd SHIFT cycle. Required: out_valid never rises, in_ready=1 the cycle after rst drops. A subsequent 8'b00000011 yields shift_amount=6, data_out=8'b11000000.
- Random round-trip: 1000 random nonzero inputs with random out_ready. For every result, BarrelShifter right shift by shift_amount reproduces data_in and data_out[7]==1.
